decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: register file, hazard/redirect FSM, ID/EX register.
// Ports: clk, rst (async low), DR, wb_*, dec/pc_mux/enbl, *_ex/_val.
module decode_stage #(
  parameter int PC_W = 7,
  parameter int I_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [I_W-1:0]  DR,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            dec,
  output logic [PC_W-1:0] pc_mux,
  output logic            enbl,
  output logic            valid_ex,
  output logic [5:0]      op_ex,
  output logic [4:0]      rd_ex,
  output logic [4:0]      rt_ex,
  output logic [31:0]     rs_val,
  output logic [31:0]     rt_val
);

  localparam logic [5:0] OP_ALU = 6'h00;
  localparam logic [5:0] OP_JMP = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    STALL
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  state_t state;
  state_t nxt;

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [I_W-1:0] replay;
  logic [I_W-1:0] cur;

  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [PC_W-1:0] target;

  logic [31:0] rs_rd;
  logic [31:0] rt_rd;

  logic is_alu;
  logic is_jmp;
  logic is_beq;
  logic is_lw;
  logic is_sw;
  logic legal;
  logic taken;
  logic hazard;
  logic issue;
  logic capture;
  logic unused_bits;

  // A stalled instruction is replayed from the
  // holding register, not from the fetch word.
  assign cur    = (state == STALL) ? replay : DR;
  assign op     = cur[31:26];
  assign rs     = cur[25:21];
  assign rt     = cur[20:16];
  assign rd     = cur[15:11];
  assign target = cur[PC_W-1:0];

  assign unused_bits = ^cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Write-first: same-cycle writeback wins
  // over the stored value.
  always_comb begin
    if (rs == 5'd0) begin
      rs_rd = '0;
    end else if (wb_en && wb_addr == rs) begin
      rs_rd = wb_data;
    end else begin
      rs_rd = rf[rs];
    end
  end

  always_comb begin
    if (rt == 5'd0) begin
      rt_rd = '0;
    end else if (wb_en && wb_addr == rt) begin
      rt_rd = wb_data;
    end else begin
      rt_rd = rf[rt];
    end
  end

  always_comb begin
    is_alu = 1'b0;
    is_jmp = 1'b0;
    is_beq = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    unique case (op)
      OP_ALU:  is_alu = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_LW:   is_lw  = 1'b1;
      OP_SW:   is_sw  = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_alu | is_jmp | is_beq
               | is_lw | is_sw;

  assign taken = is_jmp
               | (is_beq && rs_rd == rt_rd);

  // Only the instruction in EX can be a load
  // whose data is not yet on the bypass.
  assign hazard = (state == RUN)
               && ex_q.valid
               && ex_q.op == OP_LW
               && ex_q.rt != 5'd0
               && (ex_q.rt == rs || ex_q.rt == rt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= nxt;
    end
  end

  // pc_mux is held at zero unless redirecting.
  always_comb begin
    nxt     = state;
    dec     = 1'b0;
    pc_mux  = '0;
    enbl    = 1'b1;
    issue   = 1'b0;
    capture = 1'b0;
    unique case (state)
      BOOT: begin
        nxt = RUN;
      end
      FLUSH: begin
        nxt = RUN;
      end
      RUN: begin
        if (hazard) begin
          enbl    = 1'b0;
          capture = 1'b1;
          nxt     = STALL;
        end else begin
          issue = 1'b1;
          if (taken) begin
            dec    = 1'b1;
            pc_mux = target;
            nxt    = FLUSH;
          end
        end
      end
      STALL: begin
        issue = 1'b1;
        nxt   = RUN;
        if (taken) begin
          dec    = 1'b1;
          pc_mux = target;
          nxt    = FLUSH;
        end
      end
      default: begin
        nxt = BOOT;
      end
    endcase
  end

  always_comb begin
    ex_d = '0;
    if (issue && legal) begin
      ex_d.valid  = 1'b1;
      ex_d.op     = op;
      ex_d.rt     = rt;
      ex_d.rs_val = rs_rd;
      ex_d.rt_val = rt_rd;
      unique case (1'b1)
        is_alu:  ex_d.rd = rd;
        is_lw:   ex_d.rd = rt;
        default: ex_d.rd = 5'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      replay <= '0;
    end else if (capture) begin
      replay <= DR;
    end
  end

  assign valid_ex = ex_q.valid;
  assign op_ex    = ex_q.op;
  assign rd_ex    = ex_q.rd;
  assign rt_ex    = ex_q.rt;
  assign rs_val   = ex_q.rs_val;
  assign rt_val   = ex_q.rt_val;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed table, reset corners,
// and random stimulus against a flag-based reference model.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] DR;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dec;
  logic [6:0]  pc_mux;
  logic        enbl;
  logic        valid_ex;
  logic [5:0]  op_ex;
  logic [4:0]  rd_ex;
  logic [4:0]  rt_ex;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.PC_W(7), .I_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .DR       (DR),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .dec      (dec),
    .pc_mux   (pc_mux),
    .enbl     (enbl),
    .valid_ex (valid_ex),
    .op_ex    (op_ex),
    .rd_ex    (rd_ex),
    .rt_ex    (rt_ex),
    .rs_val   (rs_val),
    .rt_val   (rt_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu(
    input logic [4:0] d, input logic [4:0] s,
    input logic [4:0] t);
    return {6'h00, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] jmp(
    input logic [6:0] tg);
    return {6'h02, 19'd0, tg};
  endfunction

  function automatic logic [31:0] beq(
    input logic [4:0] s, input logic [4:0] t,
    input logic [6:0] tg);
    return {6'h04, s, t, 9'd0, tg};
  endfunction

  function automatic logic [31:0] lw(
    input logic [4:0] t, input logic [4:0] s);
    return {6'h23, s, t, 16'd0};
  endfunction

  // Reference model: pipeline situation as flags,
  // register file as a plain array.
  logic [31:0] m_rf [32];
  bit          m_boot;
  bit          m_flush;
  bit          m_stall;
  logic [31:0] m_replay;
  bit          e_valid;
  logic [5:0]  e_op;
  logic [4:0]  e_rd;
  logic [4:0]  e_rt;
  logic [31:0] e_rsv;
  logic [31:0] e_rtv;
  bit          x_dec;
  logic [6:0]  x_pc;
  bit          x_enbl;
  bit          n_valid;
  logic [5:0]  n_op;
  logic [4:0]  n_rd;
  logic [4:0]  n_rt;
  logic [31:0] n_rsv;
  logic [31:0] n_rtv;
  bit          nf;
  bit          ns;
  bit          cap;

  logic        a_dec;
  logic [6:0]  a_pc;
  logic        a_enbl;

  function automatic logic [31:0] m_read(
    input logic [4:0] i, input logic we,
    input logic [4:0] wa, input logic [31:0] wd);
    if (i == 0) return 32'd0;
    if (we && wa == i) return wd;
    return m_rf[i];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_boot = 1; m_flush = 0; m_stall = 0;
    m_replay = 0;
    e_valid = 0; e_op = 0; e_rd = 0;
    e_rt = 0; e_rsv = 0; e_rtv = 0;
  endtask

  task automatic m_eval(input logic [31:0] d,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd);
    logic [31:0] c;
    logic [5:0] op;
    logic [4:0] s, t;
    logic [31:0] a, b;
    bit known, issue;
    c  = m_stall ? m_replay : d;
    op = c[31:26];
    s  = c[25:21];
    t  = c[20:16];
    a  = m_read(s, we, wa, wd);
    b  = m_read(t, we, wa, wd);
    known = op == 6'h00 || op == 6'h02
         || op == 6'h04 || op == 6'h23
         || op == 6'h2B;
    x_dec = 0; x_pc = 0; x_enbl = 1;
    issue = 0; nf = 0; ns = 0; cap = 0;
    if (m_boot || m_flush) begin
      issue = 0;
    end else if (!m_stall && e_valid
              && e_op == 6'h23 && e_rt != 0
              && (e_rt == s || e_rt == t)) begin
      x_enbl = 0; ns = 1; cap = 1;
    end else begin
      issue = 1;
      if (op == 6'h02 || (op == 6'h04 && a == b)) begin
        x_dec = 1; x_pc = c[6:0]; nf = 1;
      end
    end
    n_valid = issue && known;
    n_op  = n_valid ? op : 6'd0;
    n_rt  = n_valid ? t : 5'd0;
    n_rsv = n_valid ? a : 32'd0;
    n_rtv = n_valid ? b : 32'd0;
    n_rd  = !n_valid ? 5'd0
          : op == 6'h00 ? c[15:11]
          : op == 6'h23 ? t : 5'd0;
  endtask

  task automatic m_commit(input logic [31:0] d,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd);
    e_valid = n_valid; e_op = n_op; e_rd = n_rd;
    e_rt = n_rt; e_rsv = n_rsv; e_rtv = n_rtv;
    m_boot = 0; m_flush = nf; m_stall = ns;
    if (cap) m_replay = d;
    if (we && wa != 0) m_rf[wa] = wd;
  endtask

  // Called at a falling edge; returns at the next one.
  task automatic step(input logic [31:0] d,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd);
    DR = d; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    m_eval(d, we, wa, wd);
    a_dec = dec; a_pc = pc_mux; a_enbl = enbl;
    chk("model dec", dec, x_dec);
    chk("model pc_mux", pc_mux, x_pc);
    chk("model enbl", enbl, x_enbl);
    @(posedge clk);
    #1;
    m_commit(d, we, wa, wd);
    chk("model valid_ex", valid_ex, e_valid);
    chk("model op_ex", op_ex, e_op);
    chk("model rd_ex", rd_ex, e_rd);
    chk("model rt_ex", rt_ex, e_rt);
    chk("model rs_val", rs_val, e_rsv);
    chk("model rt_val", rt_val, e_rtv);
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " dec"}, dec, 0);
    chk({tag, " pc_mux"}, pc_mux, 0);
    chk({tag, " enbl"}, enbl, 1);
    chk({tag, " valid_ex"}, valid_ex, 0);
    chk({tag, " op_ex"}, op_ex, 0);
    chk({tag, " rd_ex"}, rd_ex, 0);
    chk({tag, " rt_ex"}, rt_ex, 0);
    chk({tag, " rs_val"}, rs_val, 0);
    chk({tag, " rt_val"}, rt_val, 0);
  endtask

  // Asserts reset now; releases it at a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk_reset_outs(tag);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs({tag, " held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] dr;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        dec;
    logic [6:0]  pc;
    logic        enbl;
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] rsv;
    logic [31:0] rtv;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] dr, input logic we,
    input logic [4:0] wa, input logic [31:0] wd,
    input logic dc, input logic [6:0] pc,
    input logic en, input logic v,
    input logic [5:0] op, input logic [4:0] rd,
    input logic [4:0] rt, input logic [31:0] rsv,
    input logic [31:0] rtv);
    vec_t r;
    r.dr = dr; r.we = we; r.wa = wa; r.wd = wd;
    r.dec = dc; r.pc = pc; r.enbl = en; r.v = v;
    r.op = op; r.rd = rd; r.rt = rt;
    r.rsv = rsv; r.rtv = rtv;
    return r;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = 6'h00;
      1: op = 6'h02;
      2: op = 6'h04;
      3: op = 6'h23;
      4: op = 6'h2B;
      default: op = 6'h3F;
    endcase
    return {op,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            4'($urandom),
            7'($urandom)};
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mk(alu(3,1,2), 0, 0, 0,
                 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(alu(3,1,2), 0, 0, 0,
                 0, 0, 1, 1, 6'h00, 3, 2, 0, 0);
    tbl[2]  = mk(jmp(7'h15), 0, 0, 0,
                 1, 7'h15, 1, 1, 6'h02, 0, 0, 0, 0);
    tbl[3]  = mk(alu(4,1,2), 0, 0, 0,
                 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(alu(5,0,0), 1, 1, 7,
                 0, 0, 1, 1, 6'h00, 5, 0, 0, 0);
    tbl[5]  = mk(32'hFC00_0000, 1, 2, 7,
                 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(beq(1,2,7'h40), 0, 0, 0,
                 1, 7'h40, 1, 1, 6'h04, 0, 2, 7, 7);
    tbl[7]  = mk(alu(6,1,1), 0, 0, 0,
                 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(alu(7,0,0), 1, 2, 8,
                 0, 0, 1, 1, 6'h00, 7, 0, 0, 0);
    tbl[9]  = mk(beq(1,2,7'h40), 0, 0, 0,
                 0, 0, 1, 1, 6'h04, 0, 2, 7, 8);
    tbl[10] = mk(lw(5,1), 0, 0, 0,
                 0, 0, 1, 1, 6'h23, 5, 5, 7, 0);
    tbl[11] = mk(alu(8,5,2), 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(32'hDEAD_BEEF, 1, 5, 32'h1234_5678,
                 0, 0, 1, 1, 6'h00, 8, 2,
                 32'h1234_5678, 8);
    tbl[13] = mk(alu(10,0,0), 1, 0, 32'hFFFF_FFFF,
                 0, 0, 1, 1, 6'h00, 10, 0, 0, 0);
    tbl[14] = mk(alu(11,9,0), 1, 9, 32'hA5A5_0009,
                 0, 0, 1, 1, 6'h00, 11, 0,
                 32'hA5A5_0009, 0);
    tbl[15] = mk(alu(12,9,9), 0, 0, 0,
                 0, 0, 1, 1, 6'h00, 12, 9,
                 32'hA5A5_0009, 32'hA5A5_0009);

    rst = 1'b1; DR = 0; wb_en = 0;
    wb_addr = 0; wb_data = 0;
    #2;
    do_reset("reset");

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].dr, tbl[i].we,
           tbl[i].wa, tbl[i].wd);
      chk($sformatf("row%0d dec", i),
          a_dec, tbl[i].dec);
      chk($sformatf("row%0d pc_mux", i),
          a_pc, tbl[i].pc);
      chk($sformatf("row%0d enbl", i),
          a_enbl, tbl[i].enbl);
      chk($sformatf("row%0d valid_ex", i),
          valid_ex, tbl[i].v);
      chk($sformatf("row%0d op_ex", i),
          op_ex, tbl[i].op);
      chk($sformatf("row%0d rd_ex", i),
          rd_ex, tbl[i].rd);
      chk($sformatf("row%0d rt_ex", i),
          rt_ex, tbl[i].rt);
      chk($sformatf("row%0d rs_val", i),
          rs_val, tbl[i].rsv);
      chk($sformatf("row%0d rt_val", i),
          rt_val, tbl[i].rtv);
    end

    // Stalled BEQ resolves with the load data bypassed.
    do_reset("reset2");
    step(0, 0, 0, 0);
    step(lw(3, 0), 1, 4, 32'h55);
    step(beq(3, 4, 7'h2A), 0, 0, 0);
    chk("stall enbl", a_enbl, 0);
    step(0, 1, 3, 32'h55);
    chk("stall beq dec", a_dec, 1);
    chk("stall beq pc", a_pc, 7'h2A);
    step(alu(1, 0, 0), 0, 0, 0);
    chk("post-stall flush", valid_ex, 0);

    // Reset while a taken branch waits in STALL.
    step(lw(1, 0), 0, 0, 0);
    step(beq(1, 1, 7'h22), 0, 0, 0);
    DR = 0; wb_en = 0;
    #1;
    chk("pre-reset stall dec", dec, 1);
    do_reset("stall reset");
    step(alu(3, 1, 2), 0, 0, 0);
    chk("boot bubble", valid_ex, 0);
    step(alu(3, 1, 2), 0, 0, 0);
    chk("run issue", valid_ex, 1);

    // Reset while in FLUSH.
    step(jmp(7'h11), 0, 0, 0);
    do_reset("flush reset");
    step(jmp(7'h33), 0, 0, 0);
    chk("boot no redirect", a_dec, 0);
    step(alu(2, 0, 0), 0, 0, 0);
    chk("after flush reset", valid_ex, 1);

    for (int i = 0; i < 600; i++) begin
      step(rnd_ins(), 1'($urandom),
           5'($urandom_range(0, 3)),
           32'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
